// File: rtl/hit_pattern_generator_pkg.sv
// rtl/hit_pattern_generator_pkg.sv - shared FSM states, defaults and helpers for the hit pattern generator
package hit_pattern_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_WINDOW = 2'd2,
        ST_CLOSE  = 2'd3
    } gen_state_e;

    localparam int DEF_TICK_PERIOD = 40000;
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_SPC_W       = 16;

    // A programmed spacing of 0 behaves like 1, i.e. hits on consecutive cycles.
    function automatic int unsigned spacing_reload(input int unsigned spacing);
        return (spacing == 0) ? 0 : spacing - 1;
    endfunction

endpackage

// File: rtl/hit_pattern_generator_tick_strobe_gen.sv
// rtl/hit_pattern_generator_tick_strobe_gen.sv - free-running tick counter with 1-cycle tick strobe
module tick_strobe_gen #(
    parameter int TICK_PERIOD = 40000
) (
    input  logic clk40M,
    input  logic reset,
    output logic tick,
    output logic tick_next
);

    localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] LAST   = CW'(TICK_PERIOD - 1);
    localparam logic [CW-1:0] PENULT = CW'(TICK_PERIOD - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick_d is high when the following cycle will be a tick cycle.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == PENULT);
    end

    always_ff @(posedge clk40M) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign tick_next = tick_d;

endmodule

// File: rtl/hit_pattern_generator.sv
// rtl/hit_pattern_generator.sv - emits a programmed burst of hit pulses inside one tick window
module hit_pattern_generator
    import hit_pattern_generator_pkg::*;
#(
    parameter int TICK_PERIOD = DEF_TICK_PERIOD,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SPC_W       = DEF_SPC_W
) (
    input  logic             clk40M,
    input  logic             reset,
    input  logic             start,
    input  logic             loop_en,
    input  logic [CNT_W-1:0] hit_count_cfg,
    input  logic [SPC_W-1:0] hit_spacing_cfg,
    output logic             tick,
    output logic             hit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits_sent,
    output logic [15:0]      windows_done
);

    logic tick_next;

    tick_strobe_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
        .clk40M    (clk40M),
        .reset     (reset),
        .tick      (tick),
        .tick_next (tick_next)
    );

    gen_state_e       state_q, state_d;
    logic             start_r_q, start_r_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_cfg_q, cnt_cfg_d;
    logic [SPC_W-1:0] spc_cfg_q, spc_cfg_d;
    logic [SPC_W-1:0] spc_q, spc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             hit_q, hit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] hits_sent_q, hits_sent_d;
    logic [15:0]      windows_done_q, windows_done_d;

    // Hit is registered, so every decision is made for the following cycle;
    // tick_next keeps a hit from ever landing on the closing tick.
    always_comb begin
        state_d        = state_q;
        start_r_d      = start;
        edge_d         = start & ~start_r_q;
        cnt_cfg_d      = cnt_cfg_q;
        spc_cfg_d      = spc_cfg_q;
        spc_d          = spc_q;
        rem_d          = rem_q;
        hit_d          = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        hits_sent_d    = hits_sent_q;
        windows_done_d = windows_done_q;

        case (state_q)
            ST_IDLE: begin
                if (edge_q) begin
                    cnt_cfg_d   = hit_count_cfg;
                    spc_cfg_d   = hit_spacing_cfg;
                    busy_d      = 1'b1;
                    hits_sent_d = '0;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    state_d = ST_WINDOW;
                    if (cnt_cfg_q != '0) begin
                        hit_d       = 1'b1;
                        rem_d       = cnt_cfg_q - CNT_W'(1);
                        hits_sent_d = hits_sent_q + CNT_W'(1);
                        spc_d       = SPC_W'(spacing_reload(32'(spc_cfg_q)));
                    end else begin
                        rem_d = '0;
                        spc_d = '0;
                    end
                end
            end
            ST_WINDOW: begin
                if (tick) begin
                    state_d        = ST_CLOSE;
                    done_d         = 1'b1;
                    windows_done_d = windows_done_q + 16'd1;
                end else if (!tick_next && spc_q == '0 && rem_q != '0) begin
                    hit_d       = 1'b1;
                    rem_d       = rem_q - CNT_W'(1);
                    hits_sent_d = hits_sent_q + CNT_W'(1);
                    spc_d       = SPC_W'(spacing_reload(32'(spc_cfg_q)));
                end else if (spc_q != '0) begin
                    spc_d = spc_q - SPC_W'(1);
                end
            end
            ST_CLOSE: begin
                if (loop_en) begin
                    cnt_cfg_d   = hit_count_cfg;
                    spc_cfg_d   = hit_spacing_cfg;
                    hits_sent_d = '0;
                    state_d     = ST_ARM;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk40M) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            start_r_q      <= 1'b0;
            edge_q         <= 1'b0;
            cnt_cfg_q      <= '0;
            spc_cfg_q      <= '0;
            spc_q          <= '0;
            rem_q          <= '0;
            hit_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hits_sent_q    <= '0;
            windows_done_q <= '0;
        end else begin
            state_q        <= state_d;
            start_r_q      <= start_r_d;
            edge_q         <= edge_d;
            cnt_cfg_q      <= cnt_cfg_d;
            spc_cfg_q      <= spc_cfg_d;
            spc_q          <= spc_d;
            rem_q          <= rem_d;
            hit_q          <= hit_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            hits_sent_q    <= hits_sent_d;
            windows_done_q <= windows_done_d;
        end
    end

    assign hit          = hit_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hits_sent    = hits_sent_q;
    assign windows_done = windows_done_q;

endmodule

// File: tb/tb_hit_pattern_generator.sv
// tb/tb_hit_pattern_generator.sv - directed self-checking bench for hit_pattern_generator
module tb_hit_pattern_generator;

    localparam int TP    = 100;
    localparam int CNT_W = 20;
    localparam int SPC_W = 16;

    logic             clk40M = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             loop_en = 1'b0;
    logic [CNT_W-1:0] hit_count_cfg = '0;
    logic [SPC_W-1:0] hit_spacing_cfg = '0;
    logic             tick, hit, busy, done;
    logic [CNT_W-1:0] hits_sent;
    logic [15:0]      windows_done;

    hit_pattern_generator #(.TICK_PERIOD(TP), .CNT_W(CNT_W), .SPC_W(SPC_W)) dut (
        .clk40M          (clk40M),
        .reset           (reset),
        .start           (start),
        .loop_en         (loop_en),
        .hit_count_cfg   (hit_count_cfg),
        .hit_spacing_cfg (hit_spacing_cfg),
        .tick            (tick),
        .hit             (hit),
        .busy            (busy),
        .done            (done),
        .hits_sent       (hits_sent),
        .windows_done    (windows_done)
    );

    always #5 clk40M = ~clk40M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: cycle stamps, hit offsets from the last tick, and a loopback
    // hit counter (hits between consecutive ticks) compared against hits_sent.
    int cyc = 0;
    int last_tick = 0;
    int acc_hits = 0;
    int prev_win_hits = 0;
    int hit_in_tick = 0;
    int done_cnt = 0;
    int last_done = 0;
    int done_gap = 0;
    int hit_log[$];

    always @(negedge clk40M) begin
        cyc++;
        if (tick) begin
            last_tick     = cyc;
            prev_win_hits = acc_hits;
            acc_hits      = 0;
        end
        if (hit) begin
            acc_hits++;
            hit_log.push_back(cyc - last_tick);
            if (tick) hit_in_tick++;
        end
        if (done) begin
            done_cnt++;
            last_done = cyc;
            done_gap  = cyc - last_tick;
            check_eq("sb_count", 32'(hits_sent), 32'(prev_win_hits));
        end
    end

    task automatic step();
        @(negedge clk40M);
        #1;
    endtask

    task automatic wait_tick(input string tag, output int at);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 3 * TP);
        at = cyc;
        check_eq(tag, 32'(tick), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n0 = done_cnt;
        int n = 0;
        while (done_cnt == n0 && n < 5 * TP) begin
            step();
            n++;
        end
        check_eq(tag, 32'(done_cnt - n0), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_once(input int count, input int spacing);
        hit_count_cfg   = CNT_W'(count);
        hit_spacing_cfg = SPC_W'(spacing);
        hit_log.delete();
        pulse_start();
        wait_done("done_seen");
    endtask

    int t1, t2, d1, d2, d3, dc;

    initial begin
        repeat (4) step();
        check_eq("rst_tick", 32'(tick), 0);
        check_eq("rst_hit", 32'(hit), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_hits_sent", 32'(hits_sent), 0);
        check_eq("rst_windows", 32'(windows_done), 0);
        reset = 1'b0;

        // 1: free run
        wait_tick("t1_tick_a", t1);
        wait_tick("t1_tick_b", t2);
        check_eq("t1_period", 32'(t2 - t1), TP);
        check_eq("t1_no_hits", 32'(hit_log.size()), 0);
        check_eq("t1_busy", 32'(busy), 0);
        check_eq("t1_done_cnt", 32'(done_cnt), 0);
        check_eq("t1_windows", 32'(windows_done), 0);

        // 2: 10 hits, spacing 5
        run_once(10, 5);
        check_eq("t2_nhits", 32'(hit_log.size()), 10);
        check_eq("t2_first", 32'(hit_log[0]), 1);
        check_eq("t2_second", 32'(hit_log[1]), 6);
        check_eq("t2_last", 32'(hit_log[9]), 46);
        check_eq("t2_done_lat", 32'(done_gap), 1);
        check_eq("t2_hits_sent", 32'(hits_sent), 10);
        check_eq("t2_busy_at_done", 32'(busy), 1);
        step();
        check_eq("t2_busy_after", 32'(busy), 0);
        check_eq("t2_done_pulse", 32'(done), 0);

        // 3: overflow, 33 of 50 fit
        run_once(50, 3);
        check_eq("t3_nhits", 32'(hit_log.size()), 33);
        check_eq("t3_last", 32'(hit_log[32]), 97);
        check_eq("t3_hits_sent", 32'(hits_sent), 33);
        check_eq("t3_hit_in_tick", 32'(hit_in_tick), 0);
        step();

        // 4: zero count, then zero spacing
        run_once(0, 7);
        check_eq("t4a_nhits", 32'(hit_log.size()), 0);
        check_eq("t4a_hits_sent", 32'(hits_sent), 0);
        step();
        run_once(5, 0);
        check_eq("t4b_nhits", 32'(hit_log.size()), 5);
        check_eq("t4b_first", 32'(hit_log[0]), 1);
        check_eq("t4b_last", 32'(hit_log[4]), 5);
        check_eq("t4b_hits_sent", 32'(hits_sent), 5);
        check_eq("t4_windows", 32'(windows_done), 4);
        step();

        // 5: loop mode, three windows, extra start while busy
        loop_en = 1'b1;
        dc = done_cnt;
        run_once(4, 10);
        d1 = last_done;
        pulse_start();
        wait_done("t5_done2");
        d2 = last_done;
        step();
        loop_en = 1'b0;
        wait_done("t5_done3");
        d3 = last_done;
        check_eq("t5_gap12", 32'(d2 - d1), 2 * TP);
        check_eq("t5_gap23", 32'(d3 - d2), 2 * TP);
        check_eq("t5_nhits", 32'(hit_log.size()), 12);
        check_eq("t5_w3_last", 32'(hit_log[11]), 31);
        check_eq("t5_windows", 32'(windows_done), 7);
        repeat (3 * TP) step();
        check_eq("t5_no_extra_run", 32'(done_cnt - dc), 3);
        check_eq("t5_idle", 32'(busy), 0);

        // 6: reset mid-window after two hits
        hit_count_cfg   = CNT_W'(10);
        hit_spacing_cfg = SPC_W'(5);
        hit_log.delete();
        dc = done_cnt;
        pulse_start();
        t1 = 0;
        while (hit_log.size() < 2 && t1 < 4 * TP) begin
            step();
            t1++;
        end
        check_eq("t6_two_hits", 32'(hit_log.size()), 2);
        reset = 1'b1;
        step();
        check_eq("t6_rst_hit", 32'(hit), 0);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_hits_sent", 32'(hits_sent), 0);
        check_eq("t6_rst_windows", 32'(windows_done), 0);
        check_eq("t6_rst_tick", 32'(tick), 0);
        reset = 1'b0;
        repeat (3 * TP) step();
        check_eq("t6_no_done", 32'(done_cnt - dc), 0);
        run_once(3, 2);
        check_eq("t6_nhits", 32'(hit_log.size()), 3);
        check_eq("t6_last", 32'(hit_log[2]), 5);
        check_eq("t6_hits_sent", 32'(hits_sent), 3);
        check_eq("t6_windows", 32'(windows_done), 1);
        check_eq("all_hit_in_tick", 32'(hit_in_tick), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
